fp_div: RTL and testbench

FP_DIV -- requirements
Module: fp_div

---
 rtl/fp_div.sv | 119 +++++++++++
 tb/tb_fp_div.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// fp_div: fully pipelined IEEE-754 single divider, flush-to-zero, round-to-nearest-even, 14-edge latency
module fp_div (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);
    localparam int LATENCY = 14;
    localparam int N = LATENCY - 1;

    // Two restoring-division iterations per stage; quotient MSB shifts out, leaving LSBs plus guard/round
    function automatic logic [50:0] step2(input logic [24:0] q, input logic [25:0] r, input logic [23:0] d);
        logic [24:0] qn;
        logic [25:0] rn;
        logic        ge;
        qn = q;
        rn = r;
        for (int i = 0; i < 2; i++) begin
            ge = rn >= {2'b00, d};
            rn = (ge ? rn - {2'b00, d} : rn) << 1;
            qn = {qn[23:0], ge};
        end
        return {qn, rn};
    endfunction

    logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, lt;
    logic [23:0] ma, mb;

    assign sgn    = dataa[31] ^ datab[31];
    assign a_zero = dataa[30:23] == 8'h00;
    assign b_zero = datab[30:23] == 8'h00;
    assign a_inf  = dataa[30:23] == 8'hFF && dataa[22:0] == 23'd0;
    assign b_inf  = datab[30:23] == 8'hFF && datab[22:0] == 23'd0;
    assign a_nan  = dataa[30:23] == 8'hFF && dataa[22:0] != 23'd0;
    assign b_nan  = datab[30:23] == 8'hFF && datab[22:0] != 23'd0;
    assign ma     = {1'b1, dataa[22:0]};
    assign mb     = {1'b1, datab[22:0]};
    assign lt     = ma < mb;

    logic [25:0]        r_q  [N];
    logic [24:0]        q_q  [N];
    logic [23:0]        d_q  [N-1];
    logic signed [9:0]  e_q  [N];
    logic               s_q  [N];
    logic               c_q  [N];
    logic [31:0]        v_q  [N];

    logic [25:0]        r_in [N];
    logic [24:0]        q_in [N];
    logic [23:0]        d_in [N];
    logic signed [9:0]  e_in [N];
    logic               s_in [N];
    logic               c_in [N];
    logic [31:0]        v_in [N];

    // Pre-normalise so the quotient lies in [1,2): a smaller dividend mantissa is doubled
    always_comb begin
        r_in[0] = lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
        q_in[0] = '0;
        d_in[0] = mb;
        e_in[0] = $signed({2'b00, dataa[30:23]}) - $signed({2'b00, datab[30:23]}) + 10'sd127
                  - (lt ? 10'sd1 : 10'sd0);
        s_in[0] = sgn;
        c_in[0] = a_nan | b_nan | a_zero | b_zero | a_inf | b_inf;
        v_in[0] = (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) ? 32'h7FC00000 :
                  (b_zero || a_inf) ? {sgn, 8'hFF, 23'd0} : {sgn, 31'd0};
        for (int k = 1; k < N; k++) begin
            r_in[k] = r_q[k-1];
            q_in[k] = q_q[k-1];
            d_in[k] = d_q[k-1];
            e_in[k] = e_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    logic [23:0]       m;
    logic signed [9:0] ef;
    logic [31:0]       res;

    // RNE: guard set and (sticky or lsb); sticky folds round bit and remainder
    always_comb begin
        m   = {1'b0, q_q[N-1][24:2]}
              + {23'd0, q_q[N-1][1] & (q_q[N-1][0] | (|r_q[N-1]) | q_q[N-1][2])};
        ef  = e_q[N-1] + $signed({9'd0, m[23]});
        res = c_q[N-1] ? v_q[N-1] :
              ef > 10'sd254 ? {s_q[N-1], 8'hFF, 23'd0} :
              ef < 10'sd1 ? {s_q[N-1], 31'd0} :
              {s_q[N-1], ef[7:0], m[22:0]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                r_q[k] <= '0;
                q_q[k] <= '0;
                e_q[k] <= '0;
                s_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                v_q[k] <= '0;
            end
            for (int k = 0; k < N - 1; k++) d_q[k] <= '0;
            result <= '0;
        end else if (clk_en) begin
            for (int k = 0; k < N; k++) begin
                {q_q[k], r_q[k]} <= step2(q_in[k], r_in[k], d_in[k]);
                e_q[k] <= e_in[k];
                s_q[k] <= s_in[k];
                c_q[k] <= c_in[k];
                v_q[k] <= v_in[k];
            end
            for (int k = 0; k < N - 1; k++) d_q[k] <= d_in[k];
            result <= res;
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed vectors for fp_div covering latency, rounding, specials, stall and reset
module tb_fp_div;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;

    int passed = 0;
    int total = 0;

    localparam int NV = 28;
    logic [95:0] vec [NV] = '{
        {32'h40C00000, 32'h40000000, 32'h40400000},
        {32'h3F800000, 32'h40400000, 32'h3EAAAAAB},
        {32'hBF800000, 32'h40400000, 32'hBEAAAAAB},
        {32'h3F800000, 32'h00000000, 32'h7F800000},
        {32'hBF800000, 32'h00000000, 32'hFF800000},
        {32'h00000000, 32'h00000000, 32'h7FC00000},
        {32'h7F800000, 32'h7F800000, 32'h7FC00000},
        {32'h00000000, 32'h40000000, 32'h00000000},
        {32'h7F7FFFFF, 32'h3E800000, 32'h7F800000},
        {32'h00800000, 32'h4B000000, 32'h00000000},
        {32'h7FC00001, 32'h3F800000, 32'h7FC00000},
        {32'h3F800000, 32'hFF800001, 32'h7FC00000},
        {32'h7F800000, 32'h40000000, 32'h7F800000},
        {32'hFF800000, 32'h40000000, 32'hFF800000},
        {32'h40000000, 32'h7F800000, 32'h00000000},
        {32'h40000000, 32'hFF800000, 32'h80000000},
        {32'h80000000, 32'h40000000, 32'h80000000},
        {32'h00000001, 32'h3F800000, 32'h00000000},
        {32'h3F800000, 32'h00000001, 32'h7F800000},
        {32'h40400000, 32'h40000000, 32'h3FC00000},
        {32'hC0C00000, 32'h40000000, 32'hC0400000},
        {32'h00800000, 32'h3F800000, 32'h00800000},
        {32'h00800000, 32'h40000000, 32'h00000000},
        {32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF},
        {32'h7F000000, 32'h3F000000, 32'h7F800000},
        {32'h3F800000, 32'h3F800000, 32'h3F800000},
        {32'h40000000, 32'h40400000, 32'h3F2AAAAB},
        {32'h41200000, 32'h40400000, 32'h40555555}
    };

    fp_div dut (
        .clock  (clock),
        .reset_n(reset_n),
        .clk_en (clk_en),
        .dataa  (dataa),
        .datab  (datab),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset", result, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        // Back-to-back stream: pair c is captured on edge c+1 and emerges on edge c+14
        for (int c = 0; c < NV + 14; c++) begin
            if (c < 14) check($sformatf("early%0d", c), result, 32'h0);
            else check($sformatf("vec%0d", c - 14), result, vec[c-14][31:0]);
            dataa = c < NV ? vec[c][95:64] : 32'h0;
            datab = c < NV ? vec[c][63:32] : 32'h0;
            @(negedge clock);
        end

        dataa = 32'h40C00000;
        datab = 32'h40000000;
        repeat (14) @(negedge clock);
        check("fill", result, 32'h40400000);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_clr", result, 32'h0);
        @(posedge clock);
        #1 check("rst_hold", result, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        dataa = 32'h3F800000;
        datab = 32'h3F800000;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (c < 14) check($sformatf("no_stale%0d", c), result, 32'h0);
            else check("post_rst", result, 32'h3F800000);
        end

        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        dataa = 32'h40C00000;
        datab = 32'h40000000;
        for (int e = 1; e <= 19; e++) begin
            @(negedge clock);
            if (e == 1) begin dataa = 32'h3F800000; datab = 32'h40400000; end
            if (e == 2) begin dataa = 32'h40400000; datab = 32'h40000000; end
            if (e == 3) begin clk_en = 1'b0; dataa = 32'h12345678; datab = 32'h00000000; end
            if (e == 8) begin clk_en = 1'b1; dataa = 32'h3F800000; datab = 32'h3F800000; end
            if (e < 19) check($sformatf("stall_pre%0d", e), result, 32'h0);
            else check("stall_res", result, 32'h40400000);
        end
        @(negedge clock);
        check("stall_res2", result, 32'h3EAAAAAB);
        clk_en = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(negedge clock);
            check($sformatf("stall_hold%0d", e), result, 32'h3EAAAAAB);
        end
        clk_en = 1'b1;
        @(negedge clock);
        check("stall_res3", result, 32'h3FC00000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
